// File: rtl/riscv_skid_execute.sv
// Execute-to-memory elastic pipeline register with a one-entry skid slot, flush and a
// saturating backpressure counter. Upstream sees a registered ready.
module riscv_skid_execute #(
  parameter int unsigned                 XLEN          = 32,
  parameter int unsigned                 PAYLOAD_W     = 2 * XLEN + 12,
  parameter logic [PAYLOAD_W-1:0]        REGISTER_INIT = '0,
  parameter int unsigned                 CNT_W         = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [PAYLOAD_W-1:0] i_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [PAYLOAD_W-1:0] o_data,
  input  logic                 i_flush,
  output logic [1:0]           o_occupancy,
  output logic [CNT_W-1:0]     o_bp_cycles,
  input  logic                 i_bp_clr
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e                 state_q, state_d;
  logic [PAYLOAD_W-1:0]   main_q, main_d;
  logic [PAYLOAD_W-1:0]   skid_q, skid_d;
  logic                   ready_q;
  logic [CNT_W-1:0]       bp_q, bp_d;
  logic                   xfer_in, xfer_out;

  assign o_valid  = (state_q != StEmpty);
  assign o_ready  = ready_q;
  assign o_data   = main_q;
  assign o_bp_cycles = bp_q;
  assign xfer_in  = i_valid & ready_q;
  assign xfer_out = o_valid & i_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (i_flush) begin
      // Flush wins over any same-cycle transfer; data registers are left as-is.
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (xfer_in) begin
            main_d  = i_data;
            state_d = StOne;
          end
        end
        StOne: begin
          if (xfer_in && xfer_out) begin
            main_d = i_data;
          end else if (xfer_in) begin
            skid_d  = i_data;
            state_d = StTwo;
          end else if (xfer_out) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (xfer_out) begin
            main_d  = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    bp_d = bp_q;
    if (i_bp_clr) begin
      bp_d = '0;
    end else if (o_valid && !i_ready && (bp_q != {CNT_W{1'b1}})) begin
      bp_d = bp_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    o_occupancy = 2'd0;
    unique case (state_q)
      StEmpty: o_occupancy = 2'd0;
      StOne:   o_occupancy = 2'd1;
      StTwo:   o_occupancy = 2'd2;
      default: o_occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StEmpty;
      main_q  <= REGISTER_INIT;
      skid_q  <= REGISTER_INIT;
      ready_q <= 1'b1;
      bp_q    <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != StTwo);
      bp_q    <= bp_d;
    end
  end

endmodule

// File: tb/tb_riscv_skid_execute.sv
// Directed bench for riscv_skid_execute; a second CNT_W=4 instance covers counter saturation.
module tb_riscv_skid_execute;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned PAYLOAD_W = 2 * XLEN + 12;

  logic                 clk;
  logic                 rst;
  logic                 valid_in;
  logic                 ready_out;
  logic [PAYLOAD_W-1:0] data_in;
  logic                 valid_out;
  logic                 ready_in;
  logic [PAYLOAD_W-1:0] data_out;
  logic                 flush;
  logic [1:0]           occ;
  logic [15:0]          bp;
  logic                 bp_clr;

  logic                 ready_out4;
  logic                 valid_out4;
  logic [PAYLOAD_W-1:0] data_out4;
  logic [1:0]           occ4;
  logic [3:0]           bp4;

  int checks   = 0;
  int failures = 0;

  riscv_skid_execute #(.XLEN(XLEN)) u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (valid_in),
    .o_ready     (ready_out),
    .i_data      (data_in),
    .o_valid     (valid_out),
    .i_ready     (ready_in),
    .o_data      (data_out),
    .i_flush     (flush),
    .o_occupancy (occ),
    .o_bp_cycles (bp),
    .i_bp_clr    (bp_clr)
  );

  riscv_skid_execute #(.XLEN(XLEN), .CNT_W(4)) u_dut4 (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (valid_in),
    .o_ready     (ready_out4),
    .i_data      (data_in),
    .o_valid     (valid_out4),
    .i_ready     (ready_in),
    .o_data      (data_out4),
    .i_flush     (flush),
    .o_occupancy (occ4),
    .o_bp_cycles (bp4),
    .i_bp_clr    (bp_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [PAYLOAD_W-1:0] obs,
                       input logic [PAYLOAD_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic v, input logic r,
                             input logic [1:0] o);
    check({tag, "_valid"}, PAYLOAD_W'(valid_out), PAYLOAD_W'(v));
    check({tag, "_ready"}, PAYLOAD_W'(ready_out), PAYLOAD_W'(r));
    check({tag, "_occ"},   PAYLOAD_W'(occ),       PAYLOAD_W'(o));
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b1; data_in = PAYLOAD_W'(8'h77); ready_in = 1'b1;
    flush = 1'b0; bp_clr = 1'b0;
    step();
    rst = 1'b0; valid_in = 1'b0;
    check_state("reset", 1'b0, 1'b1, 2'd0);
    check("reset_data", data_out, '0);
    check("reset_bp", PAYLOAD_W'(bp), '0);

    // Single transfer: one-cycle latency.
    valid_in = 1'b1; data_in = PAYLOAD_W'(8'hA5);
    step();
    valid_in = 1'b0;
    check_state("single", 1'b1, 1'b1, 2'd1);
    check("single_data", data_out, PAYLOAD_W'(8'hA5));
    step();
    check_state("single_drain", 1'b0, 1'b1, 2'd0);

    // Back-to-back stream, no bubbles.
    for (int k = 1; k <= 8; k++) begin
      valid_in = 1'b1; data_in = PAYLOAD_W'(k);
      step();
      check("stream_data", data_out, PAYLOAD_W'(k));
      check("stream_valid", PAYLOAD_W'(valid_out), PAYLOAD_W'(1));
    end
    valid_in = 1'b0;
    step();
    check_state("stream_drain", 1'b0, 1'b1, 2'd0);
    check("stream_bp", PAYLOAD_W'(bp), '0);

    // Skid: stall with main=1 while 2 arrives.
    valid_in = 1'b1; data_in = PAYLOAD_W'(1);
    step();
    ready_in = 1'b0; data_in = PAYLOAD_W'(2);
    step();
    valid_in = 1'b0;
    check_state("skid_two", 1'b1, 1'b0, 2'd2);
    check("skid_hold", data_out, PAYLOAD_W'(1));
    step();
    check("skid_hold2", data_out, PAYLOAD_W'(1));
    ready_in = 1'b1;
    step();
    check_state("skid_one", 1'b1, 1'b1, 2'd1);
    check("skid_second", data_out, PAYLOAD_W'(2));
    step();
    check_state("skid_empty", 1'b0, 1'b1, 2'd0);
    check("skid_bp", PAYLOAD_W'(bp), PAYLOAD_W'(2));

    // Flush while TWO with a concurrent upstream beat.
    bp_clr = 1'b1;
    step();
    bp_clr = 1'b0;
    check("bp_clear", PAYLOAD_W'(bp), '0);
    ready_in = 1'b0; valid_in = 1'b1; data_in = PAYLOAD_W'(3);
    step();
    data_in = PAYLOAD_W'(4);
    step();
    check_state("flush_pre", 1'b1, 1'b0, 2'd2);
    flush = 1'b1; data_in = PAYLOAD_W'(5);
    step();
    flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    check_state("flush", 1'b0, 1'b1, 2'd0);
    check("flush_bp_kept", PAYLOAD_W'(bp), PAYLOAD_W'(2));
    step();
    check_state("flush_idle", 1'b0, 1'b1, 2'd0);
    valid_in = 1'b1; data_in = PAYLOAD_W'(6);
    step();
    valid_in = 1'b0;
    check("flush_next", data_out, PAYLOAD_W'(6));
    step();
    check_state("flush_drain", 1'b0, 1'b1, 2'd0);

    // Backpressure counter: 5 stalls, clear during a stall, then saturation.
    bp_clr = 1'b1;
    step();
    bp_clr = 1'b0; valid_in = 1'b1; data_in = PAYLOAD_W'(7); ready_in = 1'b0;
    step();
    valid_in = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("bp_five", PAYLOAD_W'(bp), PAYLOAD_W'(5));
    check("bp4_five", PAYLOAD_W'(bp4), PAYLOAD_W'(5));
    bp_clr = 1'b1;
    step();
    bp_clr = 1'b0;
    check("bp_clr_prio", PAYLOAD_W'(bp), '0);
    for (int k = 0; k < 20; k++) step();
    check("bp_twenty", PAYLOAD_W'(bp), PAYLOAD_W'(20));
    check("bp4_sat", PAYLOAD_W'(bp4), PAYLOAD_W'(15));
    check("bp_stall_data", data_out, PAYLOAD_W'(7));

    // Reset while TWO with a beat presented.
    valid_in = 1'b1; data_in = PAYLOAD_W'(8);
    step();
    check_state("rst_pre", 1'b1, 1'b0, 2'd2);
    rst = 1'b1; data_in = PAYLOAD_W'(9);
    step();
    rst = 1'b0;
    check_state("rst_mid", 1'b0, 1'b1, 2'd0);
    check("rst_mid_data", data_out, '0);
    check("rst_mid_bp", PAYLOAD_W'(bp), '0);
    ready_in = 1'b1; data_in = PAYLOAD_W'(10);
    step();
    valid_in = 1'b0;
    check("rst_next", data_out, PAYLOAD_W'(10));
    check("rst_next4", data_out4, PAYLOAD_W'(10));
    step();
    check_state("rst_drain", 1'b0, 1'b1, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
